// File: rtl/coproc.sv
// Iterative multiply/divide coprocessor: one result bit per clock, LO/HI result pair.
// Define COPROC_DIVIDE_EN to build the restoring divider; without it opcode 3 is a no-op.
module coproc #(
    parameter int WIDTH = 18
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic [10:0]      sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] cop,
    output logic             busy
);

    localparam logic       IDLE     = 1'b0;
    localparam logic       RUN      = 1'b1;
    localparam logic [2:0] OP_HI    = 3'd1;
    localparam logic [2:0] OP_MUL   = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [5:0] CNT_LOAD = 6'(WIDTH);

    logic             state_q, state_d;
    logic [5:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic             start_mul;
    logic             start_div;

    // Shift-add step: HI accumulates, the product's low half shifts into LO over the multiplier bits.
    logic [WIDTH:0]   mul_sum;
    assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});

    assign start_mul = go && (sel[2:0] == OP_MUL);

`ifdef COPROC_DIVIDE_EN
    logic           op_div_q, op_div_d;
    logic [WIDTH:0] div_shift;
    logic [WIDTH:0] div_diff;
    logic           div_fits;
    logic           unused_div;

    // Restoring step: HI is the partial remainder, quotient bits enter LO from the right.
    // A zero divisor always fits, so the quotient saturates to all ones and HI ends as the dividend.
    assign div_shift  = {hi_q, lo_q[WIDTH-1]};
    assign div_diff   = div_shift - {1'b0, a_q};
    assign div_fits   = (div_shift >= {1'b0, a_q});
    assign start_div  = go && (sel[2:0] == OP_DIV);
    assign unused_div = div_diff[WIDTH];
`else
    assign start_div  = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        a_d     = a_q;
`ifdef COPROC_DIVIDE_EN
        op_div_d = op_div_q;
`endif
        if (state_q == IDLE) begin
            if (start_mul || start_div) begin
                state_d = RUN;
                cnt_d   = CNT_LOAD;
                a_d     = a;
                lo_d    = b;
                hi_d    = '0;
`ifdef COPROC_DIVIDE_EN
                op_div_d = start_div;
`endif
            end
        end else begin
            cnt_d = cnt_q - 6'd1;
            if (cnt_q == 6'd1) begin
                state_d = IDLE;
            end
`ifdef COPROC_DIVIDE_EN
            if (op_div_q) begin
                hi_d = div_fits ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
                lo_d = {lo_q[WIDTH-2:0], div_fits};
            end else begin
                hi_d = mul_sum[WIDTH:1];
                lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
            end
`else
            hi_d = mul_sum[WIDTH:1];
            lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            a_q     <= '0;
`ifdef COPROC_DIVIDE_EN
            op_div_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            a_q     <= a_d;
`ifdef COPROC_DIVIDE_EN
            op_div_q <= op_div_d;
`endif
        end
    end

    assign busy = (state_q == RUN);
    assign cop  = (sel[2:0] == OP_HI) ? hi_q : lo_q;

    // Operand C and the upper select bits are part of the processor interface but carry nothing here.
    logic unused_inputs;
    assign unused_inputs = ^{c, sel[10:3]};

endmodule

// File: tb/tb_coproc.sv
// Directed self-checking bench for coproc at WIDTH=18; divide cases run only with COPROC_DIVIDE_EN.
module tb_coproc;

    logic        clk;
    logic        reset;
    logic        go;
    logic [10:0] sel;
    logic [17:0] a;
    logic [17:0] b;
    logic [17:0] c;
    logic [17:0] cop;
    logic        busy;

    int checks;
    int errors;
    int cycles;
    logic [17:0] lo_v;
    logic [17:0] hi_v;

    coproc #(.WIDTH(18)) dut (
        .clk   (clk),
        .reset (reset),
        .go    (go),
        .sel   (sel),
        .a     (a),
        .b     (b),
        .c     (c),
        .cop   (cop),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Issues one command at a negedge and counts the busy cycles that follow (bounded).
    task automatic applyStimulus(input logic [2:0] op, input logic [17:0] av, input logic [17:0] bv,
                                 input bit hold, output int n);
        go  = 1'b1;
        sel = {8'd0, op};
        a   = av;
        b   = bv;
        @(posedge clk);
        @(negedge clk);
        if (!hold) begin
            go = 1'b0;
            a  = '0;
            b  = '0;
        end
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        go  = 1'b0;
        sel = '0;
    endtask

    task automatic readBack(output logic [17:0] lo_o, output logic [17:0] hi_o);
        sel = 11'd0;
        #1 lo_o = cop;
        sel = 11'd1;
        #1 hi_o = cop;
        sel = 11'd0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        go     = 1'b0;
        sel    = '0;
        a      = '0;
        b      = '0;
        c      = 18'h2AAAA;

        #1;
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        readBack(lo_v, hi_v);
        checkOutput("reset_lo", {14'd0, lo_v}, 32'd0);
        checkOutput("reset_hi", {14'd0, hi_v}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        applyStimulus(3'd2, 18'd3, 18'd5, 1'b0, cycles);
        checkOutput("mul3x5_busy_cycles", cycles, 32'd18);
        readBack(lo_v, hi_v);
        checkOutput("mul3x5_lo", {14'd0, lo_v}, 32'd15);
        checkOutput("mul3x5_hi", {14'd0, hi_v}, 32'd0);

        applyStimulus(3'd2, 18'h3FFFF, 18'h3FFFF, 1'b0, cycles);
        checkOutput("mulmax_busy_cycles", cycles, 32'd18);
        readBack(lo_v, hi_v);
        checkOutput("mulmax_lo", {14'd0, lo_v}, 32'h00001);
        checkOutput("mulmax_hi", {14'd0, hi_v}, 32'h3FFFE);

        applyStimulus(3'd1, 18'h12345, 18'h54321, 1'b0, cycles);
        checkOutput("read_hi_busy", cycles, 32'd0);
        applyStimulus(3'd5, 18'h12345, 18'h54321, 1'b0, cycles);
        checkOutput("nop5_busy", cycles, 32'd0);
        readBack(lo_v, hi_v);
        checkOutput("reads_keep_lo", {14'd0, lo_v}, 32'h00001);
        checkOutput("reads_keep_hi", {14'd0, hi_v}, 32'h3FFFE);

`ifdef COPROC_DIVIDE_EN
        applyStimulus(3'd3, 18'd7, 18'd100, 1'b0, cycles);
        checkOutput("div100by7_busy_cycles", cycles, 32'd18);
        readBack(lo_v, hi_v);
        checkOutput("div100by7_lo", {14'd0, lo_v}, 32'd14);
        checkOutput("div100by7_hi", {14'd0, hi_v}, 32'd2);

        applyStimulus(3'd3, 18'd0, 18'h004D2, 1'b0, cycles);
        checkOutput("divzero_busy_cycles", cycles, 32'd18);
        readBack(lo_v, hi_v);
        checkOutput("divzero_lo", {14'd0, lo_v}, 32'h3FFFF);
        checkOutput("divzero_hi", {14'd0, hi_v}, 32'h004D2);
`else
        applyStimulus(3'd3, 18'd7, 18'd100, 1'b0, cycles);
        checkOutput("op3_nodiv_busy", cycles, 32'd0);
        readBack(lo_v, hi_v);
        checkOutput("op3_nodiv_lo", {14'd0, lo_v}, 32'h00001);
        checkOutput("op3_nodiv_hi", {14'd0, hi_v}, 32'h3FFFE);
`endif

        // Abort a multiply on its 5th RUN cycle.
        go  = 1'b1;
        sel = 11'd2;
        a   = 18'd3;
        b   = 18'd5;
        @(posedge clk);
        @(negedge clk);
        go  = 1'b0;
        sel = '0;
        repeat (4) @(negedge clk);
        checkOutput("abort_busy_before", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        checkOutput("abort_busy_after", {31'd0, busy}, 32'd0);
        readBack(lo_v, hi_v);
        checkOutput("abort_lo", {14'd0, lo_v}, 32'd0);
        checkOutput("abort_hi", {14'd0, hi_v}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        applyStimulus(3'd2, 18'd2, 18'd2, 1'b0, cycles);
        checkOutput("mul2x2_busy_cycles", cycles, 32'd18);
        readBack(lo_v, hi_v);
        checkOutput("mul2x2_lo", {14'd0, lo_v}, 32'd4);
        checkOutput("mul2x2_hi", {14'd0, hi_v}, 32'd0);

        // go stays high with opcode 2 for the whole run; 0x3FFFF*4 = 0xFFFFC.
        applyStimulus(3'd2, 18'h3FFFF, 18'd4, 1'b1, cycles);
        checkOutput("hold_go_busy_cycles", cycles, 32'd18);
        readBack(lo_v, hi_v);
        checkOutput("hold_go_lo", {14'd0, lo_v}, 32'h3FFFC);
        checkOutput("hold_go_hi", {14'd0, hi_v}, 32'h00003);
        @(negedge clk);
        checkOutput("hold_go_idle", {31'd0, busy}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
